// File: rtl/tmrx_dummy_pkg.sv
// tmrx_dummy_pkg
//   Shared types and helpers for the tmrx_dummy_acc_pipe design.
//   - state_e    : block-sequencing FSM states (IDLE, ACC, OUT)
//   - beat_width : beat counter width for a given block depth,
//                  BEAT_W = $clog2(DEPTH+1), so DEPTH itself is representable.
package tmrx_dummy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int beat_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tmrx_dummy_acc_pipe_acc_ch.sv
// tmrx_dummy_acc_ch
//   One accumulator channel. Kept as its own instance per channel so the TMR
//   flow sees a real per-channel hierarchy.
//   Optional feature macro: TMRX_DUMMY_PARITY_EN (stores an even-parity bit
//   alongside the accumulator and flags a mismatch on par_err_o).
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-high reset
//   load_i     in   first beat of a block: acc <= a & b
//   acc_en_i   in   later beat of a block: acc <= (a & b) ^ acc
//   a_i        in   channel operand
//   b_i        in   shared mask
//   acc_next_o out  value the accumulator takes on the next edge
//   par_err_o  out  stored parity disagrees with current contents (macro only)
module tmrx_dummy_acc_ch
  import tmrx_dummy_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             acc_en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef TMRX_DUMMY_PARITY_EN
  output logic             par_err_o,
`endif
  output logic [WIDTH-1:0] acc_next_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] masked;

  assign masked = a_i & b_i;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = masked;
    end else if (acc_en_i) begin
      acc_d = masked ^ acc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

`ifdef TMRX_DUMMY_PARITY_EN
  // Parity tracks acc_d every cycle, so a stored value that changes without
  // going through acc_d (an upset) shows up as a mismatch.
  logic par_q, par_d;

  assign par_d = ^acc_d;

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_err_o = (^acc_q) != par_q;
`endif

endmodule

// File: rtl/tmrx_dummy_acc_pipe.sv
// tmrx_dummy_acc_pipe
//   Multi-channel accumulator with feedback result register, used as the
//   stimulus design for the TMR regression. Input and output use valid/ready.
//   Every DEPTH accepted beats form a block; the XOR of all channel
//   accumulators is folded into res_q and presented until consumed.
//   Optional feature macro: TMRX_DUMMY_PARITY_EN (parity on acc/res_q,
//   sticky err_o). Without it err_o is constant 0.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-high reset
//   valid_i  in   input beat valid
//   ready_o  out  input beat accepted when valid_i & ready_o
//   a_i      in   NUM_CH*WIDTH operands, channel c = a_i[c*WIDTH +: WIDTH]
//   b_i      in   mask shared by all channels
//   valid_o  out  result valid
//   ready_i  in   result consumed when valid_o & ready_i
//   data_o   out  result register res_q
//   cnt_o    out  number of consumed results, wraps
//   err_o    out  error sink output (tmrx_error_sink)
module tmrx_dummy_acc_pipe
  import tmrx_dummy_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [NUM_CH*WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0]        b_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [CNT_W-1:0]        cnt_o,
  (* tmrx_error_sink *)
  output logic                    err_o
);

  localparam int BEAT_W = beat_width(DEPTH);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fire;
  logic              first;
  logic              last;
  logic              retire;
  logic [BEAT_W-1:0] beat_inc;
  logic [WIDTH-1:0]  acc_next [NUM_CH];
  logic [WIDTH-1:0]  acc_mix;
`ifdef TMRX_DUMMY_PARITY_EN
  logic [NUM_CH-1:0] ch_par_err;
`endif

  assign ready_o = (state_q != OUT) | ready_i;
  assign valid_o = (state_q == OUT);
  assign fire    = valid_i & ready_o;
  assign retire  = valid_o & ready_i;
  // In OUT, ready_o equals ready_i, so a beat accepted there always retires
  // the pending result and therefore opens a fresh block.
  assign first   = (state_q != ACC);

  assign beat_inc = first ? BEAT_W'(1) : beat_q + BEAT_W'(1);
  assign last     = fire & (beat_inc == BEAT_W'(DEPTH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tmrx_dummy_acc_ch #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (fire & first),
        .acc_en_i  (fire & ~first),
        .a_i       (a_i[gi*WIDTH +: WIDTH]),
        .b_i       (b_i),
`ifdef TMRX_DUMMY_PARITY_EN
        .par_err_o (ch_par_err[gi]),
`endif
        .acc_next_o(acc_next[gi])
      );
    end
  endgenerate

  always_comb begin
    acc_mix = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_mix = acc_mix ^ acc_next[c];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    res_d   = res_q;
    cnt_d   = cnt_q;

    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = IDLE;
    end

    if (fire) begin
      beat_d  = beat_inc;
      state_d = last ? OUT : ACC;
    end

    if (last) begin
      res_d = res_q ^ acc_mix;
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o = res_q;
  assign cnt_o  = cnt_q;

`ifdef TMRX_DUMMY_PARITY_EN
  logic res_par_q, res_par_d;
  logic err_q, err_d;

  assign res_par_d = ^res_d;
  assign err_d     = err_q | (|ch_par_err) | ((^res_q) != res_par_q);

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      res_par_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      res_par_q <= res_par_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tmrx_dummy_acc_pipe.sv
// Testbench for tmrx_dummy_acc_pipe: directed steps plus random traffic,
// checked against a block-level reference model. A second instance with
// CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_tmrx_dummy_acc_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    valid_i = 1'b0;
  logic                    ready_i = 1'b0;
  logic [NUM_CH*WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0]        b_i = '0;
  logic                    ready_o, valid_o, err_o;
  logic [WIDTH-1:0]        data_o;
  logic [7:0]              cnt_o;
  logic                    ready2_o, valid2_o, err2_o;
  logic [WIDTH-1:0]        data2_o;
  logic [1:0]              cnt2_o;

  int errors = 0;
  int checks = 0;

  // Reference model: block contents and result bookkeeping.
  bit         m_out;
  int         m_beats;
  logic [7:0] m_blk;
  logic [7:0] m_res;
  int         m_cnt;

  always #5 clk_i = ~clk_i;

  tmrx_dummy_acc_pipe #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .cnt_o(cnt_o), .err_o(err_o)
  );

  tmrx_dummy_acc_pipe #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(2)
  ) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready2_o),
    .a_i(a_i), .b_i(b_i), .valid_o(valid2_o), .ready_i(ready_i),
    .data_o(data2_o), .cnt_o(cnt2_o), .err_o(err2_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_beats = 0; m_blk = '0; m_res = '0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_o"}, {31'd0, valid_o}, {31'd0, m_out});
    chk({tag, ".data_o"}, {24'd0, data_o}, {24'd0, m_res});
    chk({tag, ".cnt_o"}, {24'd0, cnt_o}, m_cnt % 256);
    chk({tag, ".cnt2_o"}, {30'd0, cnt2_o}, m_cnt % 4);
    chk({tag, ".err_o"}, {31'd0, err_o | err2_o}, 32'd0);
  endtask

  // One clock cycle of traffic; inputs applied away from the edge.
  task automatic step(input bit v, input logic [15:0] a, input logic [7:0] b, input bit r);
    bit rdy, fire;
    valid_i = v; a_i = a; b_i = b; ready_i = r;
    rdy  = !m_out || r;
    fire = v && rdy;
    #1;
    chk("ready_o", {31'd0, ready_o}, {31'd0, rdy});
    @(posedge clk_i);
    if (m_out && r) begin
      m_cnt++;
      m_out = 0;
    end
    if (fire) begin
      m_blk = m_blk ^ (a[7:0] & b) ^ (a[15:8] & b);
      m_beats++;
      if (m_beats == DEPTH) begin
        m_res   = m_res ^ m_blk;
        m_blk   = '0;
        m_beats = 0;
        m_out   = 1;
      end
    end
    #1;
    $display("step v=%0b a=%h b=%h r=%0b -> valid=%0b data=%h cnt=%0d",
             v, a, b, r, valid_o, data_o, cnt_o);
    check_outputs("step");
  endtask

  task automatic do_reset();
    rst_ni = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    chk("rst.ready_o", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
  endtask

  initial begin
    logic [7:0] acc0, acc1;
    model_reset();

    // 1: reset values, then idle with no valid
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("t1.valid_o", {31'd0, valid_o}, 32'd0);
    chk("t1.data_o", {24'd0, data_o}, 32'h00);
    chk("t1.cnt_o", {24'd0, cnt_o}, 32'd0);
    chk("t1.err_o", {31'd0, err_o}, 32'd0);
    chk("t1.ready_o", {31'd0, ready_o}, 32'd1);
    rst_ni = 1'b0;
    repeat (3) step(0, 16'hABCD, 8'hFF, 1);

    // 2: two-beat block
    step(1, 16'hF00F, 8'hFF, 0);
    chk("t2.no_early_valid", {31'd0, valid_o}, 32'd0);
    step(1, 16'h1001, 8'h11, 0);
    acc0 = dut.g_ch[0].u_ch.acc_q;
    acc1 = dut.g_ch[1].u_ch.acc_q;
    chk("t2.acc0", {24'd0, acc0}, 32'h0E);
    chk("t2.acc1", {24'd0, acc1}, 32'hE0);
    chk("t2.data_o", {24'd0, data_o}, 32'hEE);
    chk("t2.valid_o", {31'd0, valid_o}, 32'd1);

    // 3: backpressure, valid_i ignored
    for (int i = 0; i < 5; i++) begin
      step(1, 16'($urandom), 8'($urandom), 0);
      acc0 = dut.g_ch[0].u_ch.acc_q;
      chk("t3.acc0_held", {24'd0, acc0}, 32'h0E);
      chk("t3.data_held", {24'd0, data_o}, 32'hEE);
    end

    // 4: back-to-back block, first beat in the retire cycle
    step(1, 16'hF00F, 8'hFF, 1);
    chk("t4.cnt_after_retire", {24'd0, cnt_o}, 32'd1);
    step(1, 16'h1001, 8'h11, 1);
    chk("t4.data_o", {24'd0, data_o}, 32'h00);
    step(0, 16'h0000, 8'h00, 1);
    chk("t4.cnt_o", {24'd0, cnt_o}, 32'd2);

    // 5: reset mid-block discards the partial block
    step(1, 16'h1234, 8'h56, 1);
    do_reset();
    step(1, 16'hF00F, 8'hFF, 1);
    step(1, 16'h1001, 8'h11, 1);
    chk("t5.data_o", {24'd0, data_o}, 32'hEE);
    step(0, 16'h0000, 8'h00, 1);
    chk("t5.cnt_o", {24'd0, cnt_o}, 32'd1);

    // 6: narrow counter wraps 1,2,3,0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 16'($urandom), 8'($urandom), 1);
      step(1, 16'($urandom), 8'($urandom), 1);
      step(0, 16'h0000, 8'h00, 1);
      chk("t6.cnt2_wrap", {30'd0, cnt2_o}, 32'((k + 1) % 4));
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
           bit'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
